// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: immediate format tags, base opcodes
// and small decode helpers used by the decode-stage blocks.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    // funct3 values that turn an OP-IMM style opcode into a shift
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRX);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Purely combinational immediate extraction for one 32-bit base instruction:
// classifies the format, sign-extends the immediate to DATA_WIDTH and flags
// opcodes that are not part of the base ISA for this XLEN.
module imm_extract
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_fmt_t              fmt,
    output logic                  illegal
);

    localparam bit IS_RV64 = (DATA_WIDTH == 64);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_j;
    logic [DATA_WIDTH-1:0] shamt_xlen;
    logic [DATA_WIDTH-1:0] shamt_word;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Size casts of signed operands sign-extend from their top bit; the U
    // form is sign-extended from bit 31 so RV64 sees the upper word filled.
    assign imm_i      = DATA_WIDTH'($signed(inst[31:20]));
    assign imm_s      = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
    assign imm_b      = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u      = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
    assign imm_j      = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign shamt_word = DATA_WIDTH'(inst[24:20]);
    assign shamt_xlen = IS_RV64 ? DATA_WIDTH'(inst[25:20]) : DATA_WIDTH'(inst[24:20]);

    // Opcode classification selects the immediate; unknown opcodes give zero
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_MISC_MEM, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = imm_i;
            end
            OP_OP_IMM: begin
                if (is_shift_funct3(funct3)) begin
                    fmt = FMT_SHAMT;
                    imm = shamt_xlen;
                end else begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
            end
            OP_OP_IMM_32: begin
                if (!IS_RV64) begin
                    illegal = 1'b1;
                end else if (is_shift_funct3(funct3)) begin
                    fmt = FMT_SHAMT;
                    imm = shamt_word;
                end else begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = imm_s;
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = imm_u;
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = imm_j;
            end
            OP_OP: begin
                fmt = FMT_NONE;
            end
            OP_OP_32: begin
                illegal = !IS_RV64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Decode-stage immediate generator with a two-entry skid buffer (main M,
// skid K). Outputs come straight from M; in_ready depends only on K so the
// fetch side never sees a combinational path from out_ready.
module imm_decode_pipe
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output imm_fmt_t              out_fmt,
    output logic                  out_illegal
);

    if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_width
        $error("imm_decode_pipe: DATA_WIDTH must be 32 or 64");
    end

    logic [DATA_WIDTH-1:0] dec_imm;
    imm_fmt_t              dec_fmt;
    logic                  dec_illegal;

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_imm;
    imm_fmt_t              m_fmt;
    logic                  m_illegal;

    logic                  k_valid;
    logic [DATA_WIDTH-1:0] k_imm;
    imm_fmt_t              k_fmt;
    logic                  k_illegal;

    logic                  accept;
    logic                  m_free;

    imm_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extract (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ready    = !k_valid;
    assign accept      = in_valid && in_ready;
    assign m_free      = !m_valid || out_ready;

    assign out_valid   = m_valid;
    assign out_imm     = m_imm;
    assign out_fmt     = m_fmt;
    assign out_illegal = m_illegal;

    // M refills from K first (K is older), otherwise from a new accept; a new
    // accept while M is stalled parks in K, which then blocks further input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_imm     <= '0;
            m_fmt     <= FMT_NONE;
            m_illegal <= 1'b0;
            k_valid   <= 1'b0;
            k_imm     <= '0;
            k_fmt     <= FMT_NONE;
            k_illegal <= 1'b0;
        end else if (m_free) begin
            if (k_valid) begin
                m_valid   <= 1'b1;
                m_imm     <= k_imm;
                m_fmt     <= k_fmt;
                m_illegal <= k_illegal;
                k_valid   <= 1'b0;
            end else if (accept) begin
                m_valid   <= 1'b1;
                m_imm     <= dec_imm;
                m_fmt     <= dec_fmt;
                m_illegal <= dec_illegal;
            end else begin
                m_valid   <= 1'b0;
            end
        end else if (accept) begin
            k_valid   <= 1'b1;
            k_imm     <= dec_imm;
            k_fmt     <= dec_fmt;
            k_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: one RV32 and one RV64 instance share the same
// stimulus and are checked against a behavioural decode model.
module tb_imm_decode_pipe;
    import riscv_pkg::*;

    typedef struct {
        logic [63:0] imm;
        imm_fmt_t    fmt;
        logic        ill;
    } res_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        imm_fmt_t    f32;
        logic        ill32;
        logic [63:0] imm64;
        imm_fmt_t    f64;
        logic        ill64;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32;
    imm_fmt_t    out_fmt32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    imm_fmt_t    out_fmt64;

    int errors = 0;
    int checks = 0;

    logic [31:0] acc_q[$];
    res_t        got32_q[$];
    res_t        got64_q[$];
    res_t        mon32, mon64;

    logic [6:0] ops[16] = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B, 7'h00};

    imm_decode_pipe #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_ill32)
    );

    imm_decode_pipe #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_ill64)
    );

    always #5 clk = ~clk;

    // Record every accept and every delivered result half a cycle before the edge that completes it
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready32) acc_q.push_back(in_inst);
            if (out_valid32 && out_ready) begin
                mon32.imm = {32'b0, out_imm32};
                mon32.fmt = out_fmt32;
                mon32.ill = out_ill32;
                got32_q.push_back(mon32);
            end
            if (out_valid64 && out_ready) begin
                mon64.imm = out_imm64;
                mon64.fmt = out_fmt64;
                mon64.ill = out_ill64;
                got64_q.push_back(mon64);
            end
        end
    end

    // Reference decode straight from the ISA immediate layouts, in signed integer arithmetic
    function automatic res_t ref_decode(input logic [31:0] inst, input bit rv64);
        res_t     r;
        longint   v = 0;
        imm_fmt_t f = FMT_NONE;
        bit       bad = 1'b0;
        bit       shift = (inst[14:12] == 3'd1) || (inst[14:12] == 3'd5);
        case (inst[6:0])
            7'h03, 7'h0F, 7'h67, 7'h73: begin f = FMT_I; v = longint'($signed(inst[31:20])); end
            7'h13: begin
                if (shift) begin f = FMT_SHAMT; v = rv64 ? longint'(inst[25:20]) : longint'(inst[24:20]); end
                else begin f = FMT_I; v = longint'($signed(inst[31:20])); end
            end
            7'h1B: begin
                if (!rv64) bad = 1'b1;
                else if (shift) begin f = FMT_SHAMT; v = longint'(inst[24:20]); end
                else begin f = FMT_I; v = longint'($signed(inst[31:20])); end
            end
            7'h23: begin f = FMT_S; v = longint'($signed({inst[31:25], inst[11:7]})); end
            7'h63: begin f = FMT_B; v = 2 * longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})); end
            7'h37, 7'h17: begin f = FMT_U; v = 4096 * longint'($signed(inst[31:12])); end
            7'h6F: begin f = FMT_J; v = 2 * longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})); end
            7'h33: f = FMT_NONE;
            7'h3B: bad = !rv64;
            default: bad = 1'b1;
        endcase
        if (bad) begin f = FMT_NONE; v = 0; end
        r.imm = rv64 ? v : {32'b0, v[31:0]};
        r.fmt = f;
        r.ill = bad;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues;
        acc_q.delete();
        got32_q.delete();
        got64_q.delete();
    endtask

    task automatic test_reset;
        #1;
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid32: got %0b want 0", out_valid32); end
        checks++; if (out_imm32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_imm32: got %h want 0", out_imm32); end
        checks++; if (out_fmt32 !== FMT_NONE) begin errors++; $display("[TB] FAIL reset_out_fmt32: got %0d want %0d", out_fmt32, FMT_NONE); end
        checks++; if (out_ill32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_illegal32: got %0b want 0", out_ill32); end
        checks++; if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready32: got %0b want 1", in_ready32); end
        checks++; if (out_valid64 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid64: got %0b want 0", out_valid64); end
        checks++; if (out_imm64 !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_imm64: got %h want 0", out_imm64); end
        checks++; if (out_fmt64 !== FMT_NONE) begin errors++; $display("[TB] FAIL reset_out_fmt64: got %0d want %0d", out_fmt64, FMT_NONE); end
        checks++; if (in_ready64 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready64: got %0b want 1", in_ready64); end
        in_valid = 1'b1;
        in_inst  = 32'hFFF00093;
        tick;
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_held_no_accept: got %0b want 0", out_valid32); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick;
    endtask

    task automatic test_vectors;
        vec_t v[13];
        v[0]  = '{32'hFFF00093, 32'hFFFFFFFF, FMT_I,     1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I,     1'b0};
        v[1]  = '{32'h12345037, 32'h12345000, FMT_U,     1'b0, 64'h0000000012345000, FMT_U,     1'b0};
        v[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, FMT_B,     1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_B,     1'b0};
        v[3]  = '{32'h0010006F, 32'h00000800, FMT_J,     1'b0, 64'h0000000000000800, FMT_J,     1'b0};
        v[4]  = '{32'h4030D093, 32'h00000003, FMT_SHAMT, 1'b0, 64'h0000000000000003, FMT_SHAMT, 1'b0};
        v[5]  = '{32'h43F0D093, 32'h0000001F, FMT_SHAMT, 1'b0, 64'h000000000000003F, FMT_SHAMT, 1'b0};
        v[6]  = '{32'h80000037, 32'h80000000, FMT_U,     1'b0, 64'hFFFFFFFF80000000, FMT_U,     1'b0};
        v[7]  = '{32'h0000001B, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_I,     1'b0};
        v[8]  = '{32'h00000033, 32'h00000000, FMT_NONE,  1'b0, 64'h0000000000000000, FMT_NONE,  1'b0};
        v[9]  = '{32'hFFFFFFFF, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_NONE,  1'b1};
        v[10] = '{32'hFE112E23, 32'hFFFFFFFC, FMT_S,     1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_S,     1'b0};
        v[11] = '{32'h0000003B, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000000, FMT_NONE,  1'b0};
        v[12] = '{32'h4050501B, 32'h00000000, FMT_NONE,  1'b1, 64'h0000000000000005, FMT_SHAMT, 1'b0};
        out_ready = 1'b1;
        foreach (v[i]) begin
            in_valid = 1'b1;
            in_inst  = v[i].inst;
            tick;
            in_valid = 1'b0;
            checks++; if (out_valid32 !== 1'b1) begin errors++; $display("[TB] FAIL vec%0d_valid32: got %0b want 1", i, out_valid32); end
            checks++; if (out_imm32 !== v[i].imm32) begin errors++; $display("[TB] FAIL vec%0d_imm32 inst %h: got %h want %h", i, v[i].inst, out_imm32, v[i].imm32); end
            checks++; if (out_fmt32 !== v[i].f32) begin errors++; $display("[TB] FAIL vec%0d_fmt32 inst %h: got %0d want %0d", i, v[i].inst, out_fmt32, v[i].f32); end
            checks++; if (out_ill32 !== v[i].ill32) begin errors++; $display("[TB] FAIL vec%0d_illegal32 inst %h: got %0b want %0b", i, v[i].inst, out_ill32, v[i].ill32); end
            checks++; if (out_imm64 !== v[i].imm64) begin errors++; $display("[TB] FAIL vec%0d_imm64 inst %h: got %h want %h", i, v[i].inst, out_imm64, v[i].imm64); end
            checks++; if (out_fmt64 !== v[i].f64) begin errors++; $display("[TB] FAIL vec%0d_fmt64 inst %h: got %0d want %0d", i, v[i].inst, out_fmt64, v[i].f64); end
            checks++; if (out_ill64 !== v[i].ill64) begin errors++; $display("[TB] FAIL vec%0d_illegal64 inst %h: got %0b want %0b", i, v[i].inst, out_ill64, v[i].ill64); end
        end
        tick;
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("[TB] FAIL vec_drained: got %0b want 0", out_valid32); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] insts[8];
        logic [31:0] rnd;
        res_t        e32, e64;
        for (int i = 0; i < 8; i++) begin
            rnd = $urandom();
            insts[i] = {rnd[31:7], ops[i + 2]};
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_inst  = insts[i];
            checks++; if (in_ready32 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready step %0d: got %0b want 1", i, in_ready32); end
            tick;
            e32 = ref_decode(insts[i], 1'b0);
            e64 = ref_decode(insts[i], 1'b1);
            checks++; if (out_valid32 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid step %0d: got %0b want 1", i, out_valid32); end
            checks++; if (out_imm32 !== e32.imm[31:0] || out_fmt32 !== e32.fmt) begin errors++; $display("[TB] FAIL b2b_res32 step %0d inst %h: got %h/%0d want %h/%0d", i, insts[i], out_imm32, out_fmt32, e32.imm[31:0], e32.fmt); end
            checks++; if (out_imm64 !== e64.imm || out_fmt64 !== e64.fmt) begin errors++; $display("[TB] FAIL b2b_res64 step %0d inst %h: got %h/%0d want %h/%0d", i, insts[i], out_imm64, out_fmt64, e64.imm, e64.fmt); end
        end
        in_valid = 1'b0;
        tick;
        checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got %0b/%0b want 0/0", out_valid32, out_valid64); end
    endtask

    task automatic test_backpressure;
        logic [31:0] insts[5] = '{32'hFFF00093, 32'h12345037, 32'hFE000EE3, 32'h0010006F, 32'h4030D093};
        int          idx = 0, accepts = 0, cyc = 0;
        bit          acc, stalled;
        logic [31:0] s_imm32;
        logic [63:0] s_imm64;
        imm_fmt_t    s_fmt;
        res_t        e;
        clear_queues();
        while (got32_q.size() < 5 && cyc < 40) begin
            in_valid  = (idx < 5);
            in_inst   = (idx < 5) ? insts[idx] : 32'h0;
            out_ready = (cyc >= 3);
            if (cyc == 2) begin
                checks++; if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low: got %0b/%0b want 0/0", in_ready32, in_ready64); end
                checks++; if (accepts != 2) begin errors++; $display("[TB] FAIL bp_accepts_before_full: got %0d want 2", accepts); end
            end
            acc     = in_valid && in_ready32;
            stalled = out_valid32 && !out_ready;
            s_imm32 = out_imm32;
            s_imm64 = out_imm64;
            s_fmt   = out_fmt32;
            tick;
            if (acc) begin idx++; accepts++; end
            if (stalled) begin
                checks++; if (out_valid32 !== 1'b1 || out_imm32 !== s_imm32 || out_fmt32 !== s_fmt || out_imm64 !== s_imm64) begin
                    errors++; $display("[TB] FAIL bp_stall_stable cycle %0d: got %0b/%h/%h want 1/%h/%h", cyc, out_valid32, out_imm32, out_imm64, s_imm32, s_imm64);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got32_q.size() != 5 || got64_q.size() != 5) begin errors++; $display("[TB] FAIL bp_delivered_count: got %0d/%0d want 5/5", got32_q.size(), got64_q.size()); end
        for (int i = 0; i < 5 && i < got32_q.size() && i < got64_q.size(); i++) begin
            e = ref_decode(insts[i], 1'b0);
            checks++; if (got32_q[i].imm !== e.imm || got32_q[i].fmt !== e.fmt) begin errors++; $display("[TB] FAIL bp_order32 item %0d: got %h/%0d want %h/%0d", i, got32_q[i].imm, got32_q[i].fmt, e.imm, e.fmt); end
            e = ref_decode(insts[i], 1'b1);
            checks++; if (got64_q[i].imm !== e.imm || got64_q[i].fmt !== e.fmt) begin errors++; $display("[TB] FAIL bp_order64 item %0d: got %h/%0d want %h/%0d", i, got64_q[i].imm, got64_q[i].fmt, e.imm, e.fmt); end
        end
        tick;
    endtask

    task automatic test_random;
        logic [31:0] rnd;
        bit          stalled;
        logic [31:0] s_imm32;
        logic [63:0] s_imm64;
        int          guard = 0;
        res_t        e32, e64;
        clear_queues();
        for (int c = 0; c < 300; c++) begin
            rnd       = $urandom();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = {rnd[31:7], ops[$urandom_range(0, 15)]};
            out_ready = ($urandom_range(0, 2) != 0);
            checks++; if (in_ready32 !== in_ready64) begin errors++; $display("[TB] FAIL rnd_ready_match cycle %0d: got %0b want %0b", c, in_ready64, in_ready32); end
            stalled = out_valid32 && !out_ready;
            s_imm32 = out_imm32;
            s_imm64 = out_imm64;
            tick;
            if (stalled) begin
                checks++; if (out_valid32 !== 1'b1 || out_imm32 !== s_imm32 || out_imm64 !== s_imm64) begin
                    errors++; $display("[TB] FAIL rnd_stall_stable cycle %0d: got %0b/%h/%h want 1/%h/%h", c, out_valid32, out_imm32, out_imm64, s_imm32, s_imm64);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((out_valid32 || out_valid64) && guard < 10) begin tick; guard++; end
        checks++; if (got32_q.size() != acc_q.size() || got64_q.size() != acc_q.size()) begin
            errors++; $display("[TB] FAIL rnd_count: got %0d/%0d want %0d", got32_q.size(), got64_q.size(), acc_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < got32_q.size() && i < got64_q.size(); i++) begin
            e32 = ref_decode(acc_q[i], 1'b0);
            e64 = ref_decode(acc_q[i], 1'b1);
            checks++; if (got32_q[i].imm !== e32.imm || got32_q[i].fmt !== e32.fmt || got32_q[i].ill !== e32.ill) begin
                errors++; $display("[TB] FAIL rnd_res32 item %0d inst %h: got %h/%0d/%0b want %h/%0d/%0b", i, acc_q[i], got32_q[i].imm, got32_q[i].fmt, got32_q[i].ill, e32.imm, e32.fmt, e32.ill);
            end
            checks++; if (got64_q[i].imm !== e64.imm || got64_q[i].fmt !== e64.fmt || got64_q[i].ill !== e64.ill) begin
                errors++; $display("[TB] FAIL rnd_res64 item %0d inst %h: got %h/%0d/%0b want %h/%0d/%0b", i, acc_q[i], got64_q[i].imm, got64_q[i].fmt, got64_q[i].ill, e64.imm, e64.fmt, e64.ill);
            end
        end
    endtask

    task automatic test_reset_mid;
        res_t e32, e64;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00500093;
        tick;
        in_inst   = 32'h00600093;
        tick;
        in_valid  = 1'b0;
        checks++; if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_full: got valid %0b ready %0b want 1 0", out_valid32, in_ready32); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid_drop: got %0b/%0b want 0/0", out_valid32, out_valid64); end
        checks++; if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %0b/%0b want 1/1", in_ready32, in_ready64); end
        @(negedge clk);
        #1 rst_n = 1'b1;
        clear_queues();
        tick;
        in_valid  = 1'b1;
        in_inst   = 32'hFE112E23;
        out_ready = 1'b1;
        tick;
        in_valid  = 1'b0;
        e32 = ref_decode(32'hFE112E23, 1'b0);
        e64 = ref_decode(32'hFE112E23, 1'b1);
        checks++; if (out_valid32 !== 1'b1 || out_imm32 !== e32.imm[31:0] || out_fmt32 !== e32.fmt) begin
            errors++; $display("[TB] FAIL rstmid_first32: got %0b/%h/%0d want 1/%h/%0d", out_valid32, out_imm32, out_fmt32, e32.imm[31:0], e32.fmt);
        end
        checks++; if (out_valid64 !== 1'b1 || out_imm64 !== e64.imm) begin
            errors++; $display("[TB] FAIL rstmid_first64: got %0b/%h want 1/%h", out_valid64, out_imm64, e64.imm);
        end
        tick;
        tick;
        checks++; if (got32_q.size() != 1 || got64_q.size() != 1) begin errors++; $display("[TB] FAIL rstmid_no_stale: got %0d/%0d items want 1/1", got32_q.size(), got64_q.size()); end
    endtask

    initial begin
        $display("[TB] starting imm_decode_pipe bench");
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

- Registered, handshaked immediate generator for the decode stage.
- Extracts and sign-extends the immediate of any RV32I/RV64I base instruction.
- Classifies the instruction format and flags opcodes it does not recognise.
- Buffers up to two instructions, so the fetch→decode boundary can stall without dropping or duplicating work.
- Sits between the fetch-queue output and the register-read stage; width is parametrised for RV32 and RV64 datapaths.

## Interface
- `DATA_WIDTH`, 32: XLEN of the produced immediate; only 32 or 64 are legal (elaboration error otherwise).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_inst` holds an instruction.
- `in_ready` output 1: block can accept this cycle.
- `in_inst` input 32: raw instruction word.
- `out_valid` output 1: output fields hold a result.
- `out_ready` input 1: consumer accepts this cycle.
- `out_imm` output `DATA_WIDTH`: extended immediate.
- `out_fmt` output 3: `imm_fmt_t` tag of the decoded format.
- `out_illegal` output 1: opcode not recognised; `out_imm` is 0.

## Operation
- Format decode, by `inst[6:0]`:
  - I: 0000011, 0001111, 0010011, 1100111, 1110011, 0011011 (the last only when `DATA_WIDTH`=64).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R/none (immediate 0, legal): 0110011, 0111011 (the latter only when `DATA_WIDTH`=64).
  - Anything else: ILLEGAL, with `out_illegal`=1, `out_imm`=0, `out_fmt`=FMT_NONE.
- Immediate values; all are sign-extended to `DATA_WIDTH` from the top bit shown:
  - I: `inst[31:20]`.
  - S: `{inst[31:25], inst[11:7]}`.
  - B: 13 bits, `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U: `{inst[31:12], 12'b0}`; on RV64 this is sign-extended from bit 31.
  - J: 21 bits, `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
- Shift-immediate (FMT_SHAMT): opcode 0010011 or 0011011, with funct3 001 or 101.
  - The immediate is the zero-extended shamt only; funct7 bits are stripped.
  - Opcode 0010011 on RV64 gives `inst[25:20]`.
  - Opcode 0010011 on RV32, and opcode 0011011, give `inst[24:20]`.
- Buffering: main output register M plus skid register K.
  - `in_ready` = K empty.
  - Accept (`in_valid && in_ready`) with M empty, or with M being drained this cycle: the result is written to M.
  - Accept while M is full and stalled: the result is written to K.
  - When M drains and K is full: K moves to M and K empties.
- Outputs are driven straight from M; there is no combinational path from `in_inst` to any output.

## Timing
- Latency: an instruction accepted at edge n appears on the outputs after edge n, given an empty pipe.
- Throughput: one instruction per cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `out_imm`=0, `out_fmt`=FMT_NONE, `out_illegal`=0, `in_ready`=1, K empty.
- Reset asserted mid-operation discards M and K immediately (asynchronous); nothing in flight survives.
- Handshake rules:
  - `out_valid` and all output fields stay stable while `out_valid && !out_ready`.
  - Inputs are sampled only on accept.
- `in_ready` depends on registered state only, never on `out_ready` combinationally.
- Simultaneous accept and drain with K empty: the new result goes straight to M; `out_valid` stays 1.
- Both registers full: `in_ready`=0 until M drains.

## Structure
- Shared package `riscv_pkg` holds:
  - `imm_fmt_t` enum: FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT.
  - Opcode localparams: OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_JALR, OP_SYSTEM, OP_OP_IMM_32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP, OP_OP_32.
- One sub-module, `imm_extract`: purely combinational; takes `inst` and returns imm, fmt and illegal. It is reused by the compressed-expansion path later.
- The two-entry skid buffer stays in the top module.

## Test plan
- Formats on RV32, via `in_inst`:
  - 0xFFF00093 → `out_imm` 0xFFFFFFFF, FMT_I.
  - 0x12345037 → 0x12345000, FMT_U.
  - 0xFE000EE3 → 0xFFFFFFFC, FMT_B.
  - 0x0010006F → 0x00000800, FMT_J.
- Shift stripping: 0x4030D093 (SRAI x1,x1,3) → `out_imm` 0x00000003, FMT_SHAMT. With `DATA_WIDTH`=64, 0x43F0D093 → 0x3F.
- RV64 widening: 0x80000037 → `out_imm` 0xFFFFFFFF80000000. 0x0000001B is accepted as FMT_I; with `DATA_WIDTH`=32 it gives `out_illegal`=1, `out_imm`=0.
- Backpressure:
  - Stimulus: `in_valid` held 1 with 5 distinct instructions, `out_ready` low for 3 cycles, then high.
  - Required: `in_ready` falls after 2 accepts; all 5 results are delivered in order, none lost or duplicated; outputs are stable during the stall.
- Reset mid-operation: `rst_n` is pulled low asynchronously while M and K are full.
  - `out_valid` drops to 0 before the next edge and `in_ready` returns to 1.
  - The first post-reset instruction is the next value seen.
